// File: rtl/linebuf_writer.sv
// Span-command pixel writer for the RGB565 scanline buffer in SRAM.
// Turns PIXEL/FILL/GRAD/STRIPE commands into one 16-bit SRAM write per pixel.
module linebuf_writer #(
  parameter int          STRIPE_W  = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_x,
  input  logic [10:0] cmd_len,
  input  logic [15:0] cmd_color,
  input  logic [15:0] cmd_step,
  input  logic        abort,
  output logic [15:0] sram_wr_addr,
  output logic [15:0] sram_wr_data,
  output logic        sram_wr_en,
  input  logic        sram_wr_ready,
  output logic        busy,
  output logic        done,
  output logic [10:0] pix_written
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] OP_PIXEL  = 2'd0;
  localparam logic [1:0] OP_GRAD   = 2'd2;
  localparam logic [1:0] OP_STRIPE = 2'd3;

  // Bit of the pixel offset that flips every STRIPE_W pixels.
  localparam int StripeBit = $clog2(STRIPE_W);

  state_e      state_q, state_d;
  logic        alive_q;
  logic [9:0]  x_q, x_d;
  logic [10:0] remaining_q, remaining_d;
  logic [15:0] color_q, color_d;
  logic [15:0] step_q, step_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] data_q, data_d;
  logic [10:0] idx_q, idx_d;
  logic [10:0] pix_q, pix_d;

  logic [10:0] acceptLen;
  logic [10:0] nextIdx;

  assign acceptLen = (cmd_op == OP_PIXEL) ? 11'd1 : cmd_len;
  assign nextIdx   = idx_q + 11'd1;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alive_q     <= 1'b0;
      x_q         <= '0;
      remaining_q <= '0;
      color_q     <= '0;
      step_q      <= '0;
      op_q        <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      alive_q     <= 1'b1;
      x_q         <= x_d;
      remaining_q <= remaining_d;
      color_q     <= color_d;
      step_q      <= step_d;
      op_q        <= op_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      pix_q       <= pix_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    remaining_d = remaining_q;
    color_d     = color_q;
    step_d      = step_q;
    op_d        = op_q;
    data_d      = data_q;
    idx_d       = idx_q;
    pix_d       = pix_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && alive_q) begin
          x_d         = cmd_x;
          remaining_d = acceptLen;
          color_d     = cmd_color;
          step_d      = cmd_step;
          op_d        = cmd_op;
          data_d      = cmd_color;
          idx_d       = '0;
          pix_d       = '0;
          state_d     = (acceptLen == 11'd0) ? DONE : WRITE;
        end
      end

      WRITE: begin
        if (sram_wr_ready) begin
          x_d         = x_q + 10'd1;
          remaining_d = remaining_q - 11'd1;
          pix_d       = pix_q + 11'd1;
          idx_d       = nextIdx;
          if (op_q == OP_GRAD) begin
            data_d = data_q + step_q;
          end else if (op_q == OP_STRIPE) begin
            data_d = nextIdx[StripeBit] ? 16'h0000 : color_q;
          end
        end
        // Abort wins over a same-edge final write, so it never pulses done.
        if (abort) begin
          state_d = IDLE;
        end else if (sram_wr_ready && remaining_q == 11'd1) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready    = alive_q && (state_q == IDLE);
  assign sram_wr_en   = (state_q == WRITE);
  assign busy         = (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign sram_wr_addr = BASE_ADDR + {5'b00000, x_q, 1'b0};
  assign sram_wr_data = data_q;
  assign pix_written  = pix_q;

endmodule

// File: tb/tb_linebuf_writer.sv
// Directed bench for linebuf_writer: each task drives one scenario and checks
// the captured SRAM write stream against hand-computed values.
module tb_linebuf_writer;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_x;
  logic [10:0] cmd_len;
  logic [15:0] cmd_color;
  logic [15:0] cmd_step;
  logic        abort;
  logic [15:0] sram_wr_addr;
  logic [15:0] sram_wr_data;
  logic        sram_wr_en;
  logic        sram_wr_ready;
  logic        busy;
  logic        done;
  logic [10:0] pix_written;

  int errors = 0;
  int checks = 0;

  logic [15:0] wAddr[$];
  logic [15:0] wData[$];
  int          doneCyc;
  logic        doneNext;
  logic [10:0] pixAtDone;
  int          stallBad;
  logic        acceptOk;

  linebuf_writer #(.STRIPE_W(8), .BASE_ADDR(16'h0000)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_len(cmd_len), .cmd_color(cmd_color), .cmd_step(cmd_step),
    .abort(abort),
    .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .sram_wr_en(sram_wr_en), .sram_wr_ready(sram_wr_ready),
    .busy(busy), .done(done), .pix_written(pix_written)
  );

  always #5 clk_sys = ~clk_sys;

  // Issues one command and records every accepted write until done or the cycle budget runs out.
  // Cycle c counts from the accepting edge; outputs are sampled on the falling edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [9:0] x, input logic [10:0] len,
                               input logic [15:0] color, input logic [15:0] step,
                               input bit toggleReady, input int limit);
    logic        prevStall;
    logic [15:0] pAddr, pData;
    wAddr.delete();
    wData.delete();
    doneCyc   = -1;
    doneNext  = 1'bx;
    pixAtDone = 'x;
    stallBad  = 0;
    prevStall = 1'b0;
    pAddr     = '0;
    pData     = '0;
    for (int w = 0; w < 8 && cmd_ready !== 1'b1; w++) @(negedge clk_sys);
    acceptOk  = (cmd_ready === 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_len = len; cmd_color = color; cmd_step = step;
    @(posedge clk_sys);
    #1 cmd_valid = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk_sys);
      sram_wr_ready = toggleReady ? c[0] : 1'b1;
      if (prevStall && (sram_wr_addr !== pAddr || sram_wr_data !== pData)) stallBad++;
      if (done === 1'b1) begin
        doneCyc   = c;
        pixAtDone = pix_written;
        break;
      end
      if (sram_wr_en === 1'b1 && sram_wr_ready) begin
        wAddr.push_back(sram_wr_addr);
        wData.push_back(sram_wr_data);
      end
      prevStall = (sram_wr_en === 1'b1) && !sram_wr_ready;
      pAddr     = sram_wr_addr;
      pData     = sram_wr_data;
    end
    @(negedge clk_sys);
    doneNext      = done;
    sram_wr_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    checks++; if (sram_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", sram_wr_en); end
    checks++; if (sram_wr_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0000", sram_wr_addr); end
    checks++; if (sram_wr_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0000", sram_wr_data); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    checks++; if (pix_written !== 11'd0) begin errors++; $display("[TB] FAIL reset_pix: got %0d expected 0", pix_written); end
    rst_n = 1'b1;
    @(negedge clk_sys);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_fill_full();
    int bad = 0;
    applyStimulus(2'd1, 10'd0, 11'd1024, 16'hF800, 16'h0000, 1'b0, 1100);
    checks++; if (!acceptOk) begin errors++; $display("[TB] FAIL fill_accept: got 0 expected 1"); end
    checks++; if (wAddr.size() != 1024) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 1024", wAddr.size()); end
    for (int i = 0; i < wAddr.size() && i < 1024; i++) begin
      if (wAddr[i] !== 16'(2 * i) || wData[i] !== 16'hF800) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL fill_stream: got %0d bad writes expected 0", bad); end
    checks++; if (doneCyc != 1025) begin errors++; $display("[TB] FAIL fill_done_cycle: got %0d expected 1025", doneCyc); end
    checks++; if (pixAtDone !== 11'd1024) begin errors++; $display("[TB] FAIL fill_pix: got %0d expected 1024", pixAtDone); end
    checks++; if (doneNext !== 1'b0) begin errors++; $display("[TB] FAIL fill_done_width: got %b expected 0", doneNext); end
  endtask

  task automatic test_pixel();
    applyStimulus(2'd0, 10'd1023, 11'd500, 16'h07E0, 16'h0000, 1'b0, 20);
    checks++; if (wAddr.size() != 1) begin errors++; $display("[TB] FAIL pixel_count: got %0d expected 1", wAddr.size()); end
    checks++; if (wAddr.size() > 0 && (wAddr[0] !== 16'h07FE || wData[0] !== 16'h07E0)) begin
      errors++; $display("[TB] FAIL pixel_write: got %h/%h expected 07FE/07E0", wAddr[0], wData[0]);
    end
    checks++; if (doneCyc != 2) begin errors++; $display("[TB] FAIL pixel_done_cycle: got %0d expected 2", doneCyc); end
    checks++; if (pixAtDone !== 11'd1) begin errors++; $display("[TB] FAIL pixel_pix: got %0d expected 1", pixAtDone); end
  endtask

  task automatic test_grad_stall();
    logic [15:0] expA[6] = '{16'h07F8, 16'h07FA, 16'h07FC, 16'h07FE, 16'h0000, 16'h0002};
    logic [15:0] expD[6] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
    applyStimulus(2'd2, 10'd1020, 11'd6, 16'hFFFE, 16'h0001, 1'b1, 40);
    checks++; if (wAddr.size() != 6) begin errors++; $display("[TB] FAIL grad_count: got %0d expected 6", wAddr.size()); end
    for (int i = 0; i < 6 && i < wAddr.size(); i++) begin
      checks++;
      if (wAddr[i] !== expA[i] || wData[i] !== expD[i]) begin
        errors++; $display("[TB] FAIL grad_write%0d: got %h/%h expected %h/%h", i, wAddr[i], wData[i], expA[i], expD[i]);
      end
    end
    checks++; if (stallBad != 0) begin errors++; $display("[TB] FAIL grad_stall_stable: got %0d changes expected 0", stallBad); end
    checks++; if (doneCyc != 12) begin errors++; $display("[TB] FAIL grad_done_cycle: got %0d expected 12", doneCyc); end
  endtask

  task automatic test_stripe();
    int bad = 0;
    logic [15:0] exp;
    applyStimulus(2'd3, 10'd4, 11'd20, 16'h001F, 16'h0000, 1'b0, 40);
    checks++; if (wAddr.size() != 20) begin errors++; $display("[TB] FAIL stripe_count: got %0d expected 20", wAddr.size()); end
    for (int i = 0; i < wAddr.size() && i < 20; i++) begin
      exp = (i < 8 || i >= 16) ? 16'h001F : 16'h0000;
      if (wAddr[i] !== 16'(2 * (4 + i)) || wData[i] !== exp) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL stripe_stream: got %0d bad writes expected 0", bad); end
    checks++; if (wData.size() > 12 && wData[12] !== 16'h0000) begin errors++; $display("[TB] FAIL stripe_px16: got %h expected 0000", wData[12]); end
    checks++; if (pixAtDone !== 11'd20) begin errors++; $display("[TB] FAIL stripe_pix: got %0d expected 20", pixAtDone); end
  endtask

  task automatic test_abort();
    logic sawDone = 1'b0;
    for (int w = 0; w < 8 && cmd_ready !== 1'b1; w++) @(negedge clk_sys);
    sram_wr_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_x = 10'd100; cmd_len = 11'd100; cmd_color = 16'hABCD; cmd_step = 16'h0;
    @(posedge clk_sys);
    #1 cmd_valid = 1'b0;
    repeat (11) @(negedge clk_sys);
    checks++; if (pix_written !== 11'd10) begin errors++; $display("[TB] FAIL abort_pix_before: got %0d expected 10", pix_written); end
    checks++; if (sram_wr_addr !== 16'h00DC) begin errors++; $display("[TB] FAIL abort_addr_before: got %h expected 00DC", sram_wr_addr); end
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    checks++; if (sram_wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_stop: got en=%b busy=%b expected 0/0", sram_wr_en, busy); end
    checks++; if (pix_written !== 11'd11) begin errors++; $display("[TB] FAIL abort_pix: got %0d expected 11", pix_written); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready: got %b expected 1", cmd_ready); end
    for (int k = 0; k < 3; k++) begin
      if (done === 1'b1) sawDone = 1'b1;
      @(negedge clk_sys);
    end
    checks++; if (sawDone) begin errors++; $display("[TB] FAIL abort_no_done: got 1 expected 0"); end
    applyStimulus(2'd0, 10'd3, 11'd0, 16'h1357, 16'h0000, 1'b0, 20);
    checks++; if (wAddr.size() != 1 || wAddr[0] !== 16'h0006 || wData[0] !== 16'h1357) begin
      errors++; $display("[TB] FAIL abort_next_cmd: got %0d writes expected 1 at 0006/1357", wAddr.size());
    end
  endtask

  task automatic test_zero_len();
    abort = 1'b1;
    applyStimulus(2'd1, 10'd5, 11'd0, 16'h1234, 16'h0000, 1'b0, 20);
    abort = 1'b0;
    checks++; if (wAddr.size() != 0) begin errors++; $display("[TB] FAIL zero_len_writes: got %0d expected 0", wAddr.size()); end
    checks++; if (doneCyc != 1) begin errors++; $display("[TB] FAIL zero_len_done: got %0d expected 1", doneCyc); end
    checks++; if (pixAtDone !== 11'd0) begin errors++; $display("[TB] FAIL zero_len_pix: got %0d expected 0", pixAtDone); end
  endtask

  task automatic test_reset_mid();
    for (int w = 0; w < 8 && cmd_ready !== 1'b1; w++) @(negedge clk_sys);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_x = 10'd10; cmd_len = 11'd50; cmd_color = 16'h0100; cmd_step = 16'h0003;
    @(posedge clk_sys);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk_sys);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy_before: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sram_wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stop: got en=%b busy=%b expected 0/0", sram_wr_en, busy); end
    checks++; if (pix_written !== 11'd0 || sram_wr_addr !== 16'h0000 || sram_wr_data !== 16'h0000) begin
      errors++; $display("[TB] FAIL midreset_values: got pix=%0d addr=%h data=%h expected 0/0000/0000", pix_written, sram_wr_addr, sram_wr_data);
    end
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_recover: got ready=%b busy=%b expected 1/0", cmd_ready, busy); end
    applyStimulus(2'd1, 10'd7, 11'd2, 16'h4242, 16'h0000, 1'b0, 20);
    checks++; if (wAddr.size() != 2 || wAddr[0] !== 16'h000E || wData[1] !== 16'h4242) begin
      errors++; $display("[TB] FAIL midreset_next_cmd: got %0d writes expected 2 from 000E", wAddr.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_len = '0;
    cmd_color = '0; cmd_step = '0; abort = 1'b0; sram_wr_ready = 1'b1;
    @(negedge clk_sys);
    test_reset();
    test_fill_full();
    test_pixel();
    test_grad_stall();
    test_stripe();
    test_abort();
    test_zero_len();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
